// File: rtl/top_fmap_addr_gen.sv
// top_fmap_addr_gen: row-base multiply sequencer streaming feature-map word addresses
module top_fmap_addr_gen #(
  parameter int ROW_W  = 15,
  parameter int WPR_W  = 5,
  parameter int ADDR_W = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic [ROW_W-1:0]  row_start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [WPR_W-1:0]  words_per_row,
  output logic [ROW_W-1:0]  mul_din0,
  output logic [WPR_W-1:0]  mul_din1,
  input  logic [ADDR_W-1:0] mul_dout,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              addr_last,
  output logic              frame_last
);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ISSUE, S_NEXT, S_DONE} state_t;
  localparam logic [ROW_W-1:0] ROW_ONE = 1;
  localparam logic [WPR_W-1:0] WPR_ONE = 1;
  state_t r_state, w_next;
  logic [ROW_W-1:0] r_row, r_nrows, r_rcnt;
  logic [WPR_W-1:0] r_wpr, r_wcnt;
  logic [ADDR_W-1:0] r_base;
  logic w_issue, w_xfer, w_last, w_flast, w_zero;
  assign w_issue    = r_state == S_ISSUE;
  assign w_last     = w_issue && (r_wcnt == r_wpr - WPR_ONE);
  assign w_flast    = w_last && (r_rcnt == r_nrows - ROW_ONE);
  assign w_xfer     = w_issue && addr_ready;
  assign w_zero     = (num_rows == '0) || (words_per_row == '0);
  assign ap_idle    = r_state == S_IDLE;
  assign ap_done    = r_state == S_DONE;
  assign addr_valid = w_issue;
  assign addr_last  = w_last;
  assign frame_last = w_flast;
  assign addr_o     = r_base + {{(ADDR_W-WPR_W){1'b0}}, r_wcnt};
  assign mul_din0   = r_row;
  assign mul_din1   = r_wpr;
  // state register
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // next-state: zero-work frames skip straight to DONE, last word of a row steps to NEXT or DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = ap_start ? (w_zero ? S_DONE : S_MUL) : S_IDLE;
      S_MUL:   w_next = S_ISSUE;
      S_ISSUE: w_next = (w_xfer && w_last) ? (w_flast ? S_DONE : S_NEXT) : S_ISSUE;
      S_NEXT:  w_next = S_MUL;
      default: w_next = S_IDLE;
    endcase
  end
  // latched frame inputs, row base capture and row/word counters
  always_ff @(posedge ap_clk or negedge ap_rst_n)
    if (!ap_rst_n) begin
      r_row   <= '0;
      r_nrows <= '0;
      r_wpr   <= '0;
      r_rcnt  <= '0;
      r_wcnt  <= '0;
      r_base  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (ap_start) begin
          r_row   <= row_start;
          r_nrows <= num_rows;
          r_wpr   <= words_per_row;
          r_rcnt  <= '0;
          r_wcnt  <= '0;
        end
        S_MUL:   r_base <= mul_dout;
        S_ISSUE: if (w_xfer && !w_last) r_wcnt <= r_wcnt + WPR_ONE;
        S_NEXT: begin
          r_row  <= r_row + ROW_ONE;
          r_rcnt <= r_rcnt + ROW_ONE;
          r_wcnt <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_top_fmap_addr_gen.sv
// tb_top_fmap_addr_gen: scoreboard bench for the feature-map address sequencer
module tb_top_fmap_addr_gen;
  logic ap_clk = 0, ap_rst_n = 0, ap_start = 0, addr_ready;
  logic ap_idle, ap_done, addr_valid, addr_last, frame_last;
  logic [14:0] row_start = 0, num_rows = 0, mul_din0;
  logic [4:0] words_per_row = 0, mul_din1;
  logic [15:0] mul_dout, addr_o;
  logic [19:0] w_prod;
  typedef struct packed {logic [15:0] a; logic l; logic f;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0, cyc = 0, last_cyc = 0;
  bit bp = 0, pstall = 0;
  logic [15:0] pa;
  logic pl, pf;

  top_fmap_addr_gen dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .row_start(row_start), .num_rows(num_rows), .words_per_row(words_per_row),
    .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .addr_o(addr_o), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .addr_last(addr_last), .frame_last(frame_last)
  );

  assign w_prod = mul_din0 * mul_din1;
  assign mul_dout = w_prod[15:0];

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  initial begin
    addr_ready = 1;
    forever begin
      @(posedge ap_clk);
      #1 addr_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_row(input logic [15:0] base, input int wp, input bit fin);
    for (int i = 0; i < wp; i++) sb.push_back({base + 16'(i), i == wp - 1, fin && (i == wp - 1)});
  endtask

  // monitor: pops expected transfers and checks stability under backpressure
  always @(negedge ap_clk) begin
    exp_t e;
    if (!ap_rst_n) pstall = 0;
    else begin
      if (pstall) begin
        check("stall_valid", addr_valid, 1);
        check("stall_addr", addr_o, pa);
        check("stall_last", addr_last, pl);
        check("stall_flast", frame_last, pf);
      end
      if (addr_valid && addr_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got addr %0h expected no transfer", addr_o);
        end else begin
          e = sb.pop_front();
          check("addr", addr_o, e.a);
          check("addr_last", addr_last, e.l);
          check("frame_last", frame_last, e.f);
        end
        if (frame_last) last_cyc = cyc;
      end
      pstall = addr_valid && !addr_ready;
      pa = addr_o;
      pl = addr_last;
      pf = frame_last;
    end
  end

  task automatic run_frame(input logic [14:0] rs, input logic [14:0] nr, input logic [4:0] wp,
                           input int off, input bit disturb);
    int cs;
    bit got, zero;
    zero = (nr == 0) || (wp == 0);
    got = 0;
    @(posedge ap_clk);
    #1;
    row_start = rs;
    num_rows = nr;
    words_per_row = wp;
    ap_start = 1;
    cs = cyc;
    @(posedge ap_clk);
    #1 ap_start = 0;
    @(negedge ap_clk);
    if (!zero) begin
      check("mul_valid", addr_valid, 0);
      check("mul_idle", ap_idle, 0);
    end
    for (int n = 0; n < 3000; n++) begin
      if (ap_done) begin
        got = 1;
        break;
      end
      if (disturb && n == 3) begin
        ap_start = 1;
        row_start = 15'd100;
        num_rows = 15'd9;
        words_per_row = 5'd7;
      end
      if (disturb && n == 5) ap_start = 0;
      @(negedge ap_clk);
    end
    check("done_seen", got, 1);
    if (got) begin
      if (off >= 0) check("done_latency", cyc - cs, off);
      if (!zero) check("done_after_last", cyc - last_cyc, 1);
      check("sb_empty", sb.size(), 0);
    end
    @(negedge ap_clk);
    check("idle_after_done", ap_idle, 1);
    check("done_pulse_width", ap_done, 0);
  endtask

  initial begin
    #2;
    check("rst_idle", ap_idle, 1);
    check("rst_done", ap_done, 0);
    check("rst_valid", addr_valid, 0);
    check("rst_addr", addr_o, 0);
    check("rst_last", {addr_last, frame_last}, 0);
    @(posedge ap_clk);
    #1 ap_rst_n = 1;

    push_row(16'd12, 4, 0);
    push_row(16'd16, 4, 1);
    run_frame(15'd3, 15'd2, 5'd4, 12, 0);

    bp = 1;
    push_row(16'd12, 4, 0);
    push_row(16'd16, 4, 1);
    run_frame(15'd3, 15'd2, 5'd4, -1, 0);
    bp = 0;

    run_frame(15'd3, 15'd2, 5'd0, 1, 0);
    run_frame(15'd3, 15'd0, 5'd4, 1, 0);

    push_row(16'h7FE1, 31, 0);
    push_row(16'h0000, 31, 1);
    run_frame(15'h7FFF, 15'd2, 5'd31, 66, 0);

    push_row(16'hFFFF, 5, 1);
    run_frame(15'd13107, 15'd1, 5'd5, 7, 0);

    push_row(16'd12, 4, 0);
    push_row(16'd16, 4, 1);
    run_frame(15'd3, 15'd2, 5'd4, 12, 1);

    push_row(16'd12, 4, 0);
    push_row(16'd16, 4, 1);
    @(posedge ap_clk);
    #1;
    row_start = 15'd3;
    num_rows = 15'd2;
    words_per_row = 5'd4;
    ap_start = 1;
    @(posedge ap_clk);
    #1 ap_start = 0;
    repeat (4) @(negedge ap_clk);
    check("pre_rst_valid", addr_valid, 1);
    #2 ap_rst_n = 0;
    #1;
    check("mid_rst_valid", addr_valid, 0);
    check("mid_rst_idle", ap_idle, 1);
    check("mid_rst_done", ap_done, 0);
    check("mid_rst_addr", addr_o, 0);
    check("mid_rst_last", {addr_last, frame_last}, 0);
    check("mid_rst_din", {mul_din0, mul_din1}, 0);
    sb.delete();
    @(posedge ap_clk);
    #1 ap_rst_n = 1;
    push_row(16'd15, 3, 1);
    run_frame(15'd5, 15'd1, 5'd3, 5, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/top_fmap_addr_gen.md
Name: top_fmap_addr_gen

Overview:
Row-address sequencer that sits upstream of top_mul_mul_15ns_ibs (15-bit × 5-bit unsigned multiplier, 16-bit truncated product, combinational). It drives the multiplier operands (row index, words-per-row) and consumes the product as a row base address. It then streams word addresses for each row of a feature map to the BNN buffer read port over a valid/ready handshake. Control uses the ap_start/ap_done/ap_idle block protocol.

Parameters:
ROW_W, 15, row index / row count width (multiplier din0 width)
WPR_W, 5, words-per-row width (multiplier din1 width)
ADDR_W, 16, address width (multiplier dout width)

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  start request, sampled only in IDLE
ap_idle  out  1  high in IDLE
ap_done  out  1  one-cycle pulse at end of frame
row_start  in  ROW_W  first row index, latched at start
num_rows  in  ROW_W  rows to issue, latched at start
words_per_row  in  WPR_W  words per row, latched at start
mul_din0  out  ROW_W  current row register, to multiplier din0
mul_din1  out  WPR_W  latched words_per_row, to multiplier din1
mul_dout  in  ADDR_W  product from multiplier
addr_o  out  ADDR_W  word address
addr_valid  out  1  addr_o valid
addr_ready  in  1  consumer accepts addr_o
addr_last  out  1  addr_o is the last word of its row
frame_last  out  1  addr_o is the last word of the frame

Behaviour:
- Reset (async, any state): FSM=IDLE; ap_idle=1; ap_done, addr_valid, addr_last, frame_last=0; addr_o, all counters and latched-input registers=0. Any in-flight frame is abandoned and nothing is replayed.
- mul_din0/mul_din1 come directly from registers. The multiplier is combinational, so mul_dout is valid in the same cycle.
- FSM states: IDLE, MUL, ISSUE, NEXT, DONE.
- IDLE: on ap_start=1, latch row_start, num_rows and words_per_row, and clear the row and word counters.
  - If num_rows=0 or words_per_row=0, go to DONE and emit no addresses.
  - Otherwise go to MUL.
- MUL (1 cycle): capture base <= mul_dout. Go to ISSUE.
- ISSUE:
  - addr_valid=1; addr_o = base + word_cnt, mod 2^ADDR_W (wrap, no saturation).
  - addr_last = (word_cnt == wpr-1); frame_last = addr_last && (row_cnt == num_rows-1).
  - A transfer occurs when addr_valid && addr_ready.
  - On a transfer with !addr_last: word_cnt++.
  - On a transfer with addr_last and !frame_last: go to NEXT.
  - On a transfer with frame_last: go to DONE.
  - Without a transfer, addr_o, addr_last and frame_last stay stable.
- NEXT (1 cycle): addr_valid=0; cur_row = cur_row + 1 mod 2^ROW_W (wraps 0x7FFF -> 0); row_cnt++; word_cnt=0. Go to MUL.
- DONE (1 cycle): ap_done=1; ap_idle=0; addr_valid=0. Go to IDLE.
- ap_idle=1 only in IDLE. ap_start is ignored outside IDLE. Input port changes after the latch have no effect.
- Latency:
  - Start to first addr_valid: 2 cycles (start cycle, then MUL).
  - Between rows: 2 bubble cycles (NEXT, MUL).
  - Final transfer to ap_done: 1 cycle.
  - Zero-work frame: ap_done 1 cycle after start.
- Product truncation is the multiplier's behaviour (low 16 bits). This block uses mul_dout unmodified.

Test Plan:
- Basic frame: row_start=3, num_rows=2, words_per_row=4, addr_ready=1 -> addresses 12,13,14,15 then 16,17,18,19. addr_last on 15 and 19; frame_last only on 19. ap_done pulses 1 cycle after 19 and ap_idle returns next cycle. Exactly 8 transfers.
- Backpressure: same frame, addr_ready toggled pseudo-randomly -> same address sequence with no drops or duplicates. addr_o, addr_last and frame_last stay stable while valid && !ready.
- Zero work: words_per_row=0 (then separately num_rows=0) -> addr_valid never asserts; ap_done pulses exactly 1 cycle after ap_start.
- Wrap: row_start=0x7FFF, num_rows=2, words_per_row=31.
  - Row 0: base = 0x7FFF×31 mod 2^16 = 0x7FE1; addresses 0x7FE1..0x7FFF.
  - Row 1: row wraps to 0, base 0; addresses 0..30.
  - Separately, force a base near 0xFFFF and check that addresses wrap to 0.
- Busy start and mid-frame reset: pulse ap_start and change all inputs during ISSUE -> sequence unchanged. Then assert ap_rst_n=0 mid-row -> all outputs reach reset values immediately. After release, a new start runs a clean frame from its own row_start.
